// File: rtl/sync_up_counter_ctl.sv
// Programmable up counter (0..LIMIT) with start/stop control, one-shot or periodic mode.
// Registered outputs; TC/DONE are single-cycle pulses, STOP beats START beats counting.
module sync_up_counter_ctl #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         START,
    input  logic         STOP,
    input  logic         PERIODIC,
    input  logic [W-1:0] LIMIT,
    output logic [W-1:0] COUNT,
    output logic         TC,
    output logic         DONE,
    output logic         BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   count_nxt;
    logic [W-1:0]   lim_q, lim_nxt;
    logic           per_q, per_nxt;
    logic           tc_nxt, done_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            COUNT <= '0;
            lim_q <= '0;
            per_q <= 1'b0;
            TC    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            COUNT <= count_nxt;
            lim_q <= lim_nxt;
            per_q <= per_nxt;
            TC    <= tc_nxt;
            DONE  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = COUNT;
        lim_nxt   = lim_q;
        per_nxt   = per_q;
        tc_nxt    = 1'b0;
        done_nxt  = 1'b0;

        if (STOP) begin
            // abort leaves COUNT frozen so software can read where it stopped
            state_nxt = IDLE;
        end else if (START) begin
            state_nxt = RUN;
            count_nxt = '0;
            lim_nxt   = LIMIT;
            per_nxt   = PERIODIC;
        end else if (state == RUN && EN) begin
            if (COUNT == lim_q) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
                if (!per_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                count_nxt = COUNT + W'(1);
            end
        end
    end

    assign BUSY = (state == RUN);

endmodule
